// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM state encoding
// and the binary-to-BCD conversion used for the credit display.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_LOCKED = 3'd2,
    S_VEND   = 3'd3,
    S_CHANGE = 3'd4
  } state_e;

  localparam int BCD_W = 16;

  // Double dabble; credit never exceeds 999, so the thousands digit stays 0.
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [9:0] bin);
    logic [BCD_W-1:0] bcd;
    bcd = '0;
    for (int i = 9; i >= 0; i--) begin
      for (int d = 0; d < 4; d++)
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      bcd = {bcd[BCD_W-2:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/vend_ctrl_edge_detect.sv
// Registers a vector of debounced levels once and flags rising edges
// (current sample high, previous sample low) as one-cycle pulses.
module edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] cur_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= lvl_i;
      prev_q <= cur_q;
    end
  end

  assign rise_o = cur_q & ~prev_q;

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: credit accumulation, lock at price,
// timed vend, cancel/timeout refund and metered change pay-out.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                     PRICE       = 25,
  parameter int                     NUM_COINS   = 3,
  parameter logic [NUM_COINS*8-1:0] COIN_VALUES = {8'd25, 8'd10, 8'd5},
  parameter int                     CREDIT_W    = 8,
  parameter int                     CHANGE_UNIT = 5,
  parameter int                     TIMEOUT_CYC = 100_000_000,
  parameter int                     DISP_CYC    = 4,
  parameter int                     PULSE_GAP   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic                 dispense_btn,
  input  logic                 cancel_btn,
  output logic [CREDIT_W-1:0]  credit,
  output logic [BCD_W-1:0]     credit_bcd,
  output logic                 locked_led,
  output logic                 dispense_led,
  output logic                 change_pulse,
  output logic                 change_busy,
  output logic                 coin_reject
);

  localparam int MAXC_I  = ((1 << CREDIT_W) - 1 < 999) ? (1 << CREDIT_W) - 1 : 999;
  localparam int CNT_MAX = (DISP_CYC > PULSE_GAP) ? DISP_CYC : PULSE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [31:0]         MAXC    = 32'(MAXC_I);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CNT_W-1:0]    DISP_LAST = CNT_W'(DISP_CYC - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(PULSE_GAP - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                locked_q, disp_q, pulse_q, busy_q, rej_q;

  logic [NUM_COINS-1:0] coin_ev;
  logic [1:0]           btn_ev;
  logic                 dispense_ev, cancel_ev;

  edge_detect #(.W(NUM_COINS)) u_coin_ed (
    .clk(clk), .rst_n(rst_n), .lvl_i(coin_in), .rise_o(coin_ev)
  );

  edge_detect #(.W(2)) u_btn_ed (
    .clk(clk), .rst_n(rst_n), .lvl_i({dispense_btn, cancel_btn}), .rise_o(btn_ev)
  );

  assign dispense_ev = btn_ev[1];
  assign cancel_ev   = btn_ev[0];

  // Lowest-index channel wins; any extra simultaneous edge is a reject.
  logic                coin_any, coin_multi, coin_fits, coin_ok;
  logic [7:0]          coin_val;
  logic [31:0]         coin_sum;
  logic [CREDIT_W-1:0] add_credit;

  always_comb begin
    coin_val = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--)
      if (coin_ev[i]) coin_val = COIN_VALUES[i*8 +: 8];
    coin_any   = |coin_ev;
    coin_multi = |(coin_ev & (coin_ev - NUM_COINS'(1)));
    coin_sum   = 32'(credit_q) + 32'(coin_val);
    coin_fits  = (coin_sum <= MAXC);
    coin_ok    = coin_any && coin_fits;
    add_credit = coin_ok ? CREDIT_W'(coin_sum) : credit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      locked_q <= 1'b0;
      disp_q   <= 1'b0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      rej_q   <= coin_any;
      tmo_q   <= '0;
      case (state_q)
        S_IDLE, S_ACCUM: begin
          rej_q    <= coin_multi || (coin_any && !coin_fits);
          credit_q <= add_credit;
          if (state_q == S_ACCUM && !coin_any) tmo_q <= tmo_q + TMO_W'(1);
          if (state_q == S_ACCUM &&
              (cancel_ev || (!coin_any && tmo_q == TMO_LAST))) begin
            // Refund starts with a pulse on the very first CHANGE cycle.
            state_q  <= S_CHANGE;
            credit_q <= add_credit - UNIT_C;
            pulse_q  <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end else if (add_credit >= PRICE_C) begin
            state_q  <= S_LOCKED;
            locked_q <= 1'b1;
          end else if (coin_ok) begin
            state_q <= S_ACCUM;
          end
        end
        S_LOCKED: begin
          if (dispense_ev) begin
            state_q  <= S_VEND;
            credit_q <= credit_q - PRICE_C;
            locked_q <= 1'b0;
            disp_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        S_VEND: begin
          if (cnt_q == DISP_LAST) begin
            disp_q <= 1'b0;
            cnt_q  <= '0;
            if (credit_q != '0) begin
              state_q  <= S_CHANGE;
              credit_q <= credit_q - UNIT_C;
              pulse_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CHANGE: begin
          if (credit_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            credit_q <= credit_q - UNIT_C;
            pulse_q  <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign credit       = credit_q;
  assign credit_bcd   = bin2bcd(10'(credit_q));
  assign locked_led   = locked_q;
  assign dispense_led = disp_q;
  assign change_pulse = pulse_q;
  assign change_busy  = busy_q;
  assign coin_reject  = rej_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scenario bench for vend_ctrl with a short timeout; a transaction-level
// credit/pay-out model predicts credit, lock, rejects and change pulses.
module tb_vend_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  coin_in = '0;
  logic        dispense_btn = 1'b0;
  logic        cancel_btn = 1'b0;
  logic [7:0]  credit;
  logic [15:0] credit_bcd;
  logic        locked_led, dispense_led, change_pulse, change_busy, coin_reject;

  int total = 0;
  int bad = 0;
  int cyc = 0, pulse_cnt = 0, rej_cnt = 0, disp_cnt = 0, last_pulse = 0, pulse_gap = 0;
  int vals[3] = '{5, 10, 25};

  vend_ctrl #(.TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .dispense_btn(dispense_btn),
    .cancel_btn(cancel_btn), .credit(credit), .credit_bcd(credit_bcd),
    .locked_led(locked_led), .dispense_led(dispense_led), .change_pulse(change_pulse),
    .change_busy(change_busy), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (change_pulse) begin
      pulse_cnt  <= pulse_cnt + 1;
      pulse_gap  <= cyc - last_pulse;
      last_pulse <= cyc;
    end
    if (coin_reject)  rej_cnt  <= rej_cnt + 1;
    if (dispense_led) disp_cnt <= disp_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_bcd(input int c);
    return 16'(((c / 100) << 8) | (((c / 10) % 10) << 4) | (c % 10));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic coin(input int ch);
    coin_in[ch] = 1'b1;
    tick(1);
    coin_in[ch] = 1'b0;
    tick(3);
  endtask

  task automatic press(input bit disp);
    if (disp) dispense_btn = 1'b1; else cancel_btn = 1'b1;
    tick(1);
    dispense_btn = 1'b0;
    cancel_btn   = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(credit == 0 && !locked_led && !dispense_led && !change_busy) && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (!(credit == 0 && !locked_led && !dispense_led && !change_busy)) begin
      bad++;
      $display("FAIL wait_idle: credit=%0d busy=%b locked=%b after %0d cycles",
               credit, change_busy, locked_led, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #20;
    total++;
    if (credit !== 8'd0) begin bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
    total++;
    if (credit_bcd !== 16'h0) begin bad++; $display("FAIL reset_bcd: got %h want 0000", credit_bcd); end
    total++;
    if ({locked_led, dispense_led, change_pulse, change_busy, coin_reject} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 00000",
               {locked_led, dispense_led, change_pulse, change_busy, coin_reject});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_exact();
    int d0, p0;
    int exp_seq[3] = '{10, 20, 25};
    int ch_seq[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      coin(ch_seq[i]);
      total++;
      if (credit !== 8'(exp_seq[i])) begin
        bad++; $display("FAIL exact_credit%0d: got %0d want %0d", i, credit, exp_seq[i]);
      end
    end
    total++;
    if (locked_led !== 1'b1) begin bad++; $display("FAIL exact_locked: got %b want 1", locked_led); end
    total++;
    if (credit_bcd !== exp_bcd(25)) begin bad++; $display("FAIL exact_bcd: got %h want 0025", credit_bcd); end
    d0 = disp_cnt; p0 = pulse_cnt;
    press(1'b1);
    wait_idle(100);
    total++;
    if (disp_cnt - d0 !== 4) begin bad++; $display("FAIL exact_disp_cycles: got %0d want 4", disp_cnt - d0); end
    total++;
    if (pulse_cnt - p0 !== 0) begin bad++; $display("FAIL exact_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_change_locked();
    int r0, p0;
    repeat (3) coin(1);
    total++;
    if (credit !== 8'd30 || locked_led !== 1'b1) begin
      bad++; $display("FAIL dimes3: credit=%0d locked=%b want 30/1", credit, locked_led);
    end
    r0 = rej_cnt;
    coin(0);
    total++;
    if (rej_cnt - r0 !== 1 || credit !== 8'd30) begin
      bad++; $display("FAIL locked_reject: rejects=%0d credit=%0d want 1/30", rej_cnt - r0, credit);
    end
    total++;
    if (credit_bcd !== exp_bcd(30)) begin bad++; $display("FAIL bcd30: got %h want 0030", credit_bcd); end
    p0 = pulse_cnt;
    press(1'b1);
    wait_idle(100);
    total++;
    if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL change5_pulses: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_simul();
    int r0, p0;
    r0 = rej_cnt;
    coin_in = 3'b011;
    tick(1);
    coin_in = 3'b000;
    tick(3);
    total++;
    if (credit !== 8'd5 || rej_cnt - r0 !== 1) begin
      bad++; $display("FAIL simul: credit=%0d rejects=%0d want 5/1", credit, rej_cnt - r0);
    end
    coin(2);
    total++;
    if (credit !== 8'd30 || locked_led !== 1'b1) begin
      bad++; $display("FAIL simul_quarter: credit=%0d locked=%b want 30/1", credit, locked_led);
    end
    p0 = pulse_cnt;
    press(1'b1);
    wait_idle(100);
    total++;
    if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL simul_pulses: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_cancel_timeout();
    int p0;
    coin(0);
    p0 = pulse_cnt;
    press(1'b0);
    wait_idle(50);
    total++;
    if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL cancel_pulses: got %0d want 1", pulse_cnt - p0); end
    coin(1);
    p0 = pulse_cnt;
    wait_idle(200);
    total++;
    if (pulse_cnt - p0 !== 2) begin bad++; $display("FAIL timeout_pulses: got %0d want 2", pulse_cnt - p0); end
    total++;
    if (pulse_gap !== 2) begin bad++; $display("FAIL timeout_gap: got %0d want 2", pulse_gap); end
  endtask

  task automatic test_reset_mid();
    int n = 0, p0;
    coin(1);
    coin(1);
    cancel_btn = 1'b1;
    tick(1);
    cancel_btn = 1'b0;
    while (!change_busy && n < 10) begin tick(1); n++; end
    total++;
    if (change_busy !== 1'b1 || credit !== 8'd15) begin
      bad++; $display("FAIL mid_change_entry: busy=%b credit=%0d want 1/15", change_busy, credit);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({credit, locked_led, dispense_led, change_pulse, change_busy, coin_reject} !== 13'b0) begin
      bad++; $display("FAIL mid_reset_outs: credit=%0d busy=%b pulse=%b want all 0",
                      credit, change_busy, change_pulse);
    end
    tick(1);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    tick(10);
    total++;
    if (pulse_cnt - p0 !== 0 || credit !== 8'd0 || change_busy !== 1'b0) begin
      bad++; $display("FAIL mid_after_release: pulses=%0d credit=%0d busy=%b want 0/0/0",
                      pulse_cnt - p0, credit, change_busy);
    end
  endtask

  task automatic test_hold();
    int maxc = 0, p0;
    p0 = pulse_cnt;
    coin_in[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (int'(credit) > maxc) maxc = int'(credit);
    end
    coin_in[0] = 1'b0;
    tick(2);
    total++;
    if (maxc !== 5) begin bad++; $display("FAIL hold_max_credit: got %0d want 5", maxc); end
    total++;
    if (pulse_cnt - p0 !== 1 || credit !== 8'd0) begin
      bad++; $display("FAIL hold_refund: pulses=%0d credit=%0d want 1/0", pulse_cnt - p0, credit);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int exp_cr, exp_rej, exp_pay, n, ch, r0, p0;
      bit lk;
      exp_cr = 0; exp_rej = 0; lk = 1'b0;
      r0 = rej_cnt;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        ch = $urandom_range(0, 2);
        coin(ch);
        if (lk) exp_rej++;
        else begin
          exp_cr += vals[ch];
          if (exp_cr >= 25) lk = 1'b1;
        end
        total++;
        if (credit !== 8'(exp_cr) || locked_led !== lk || credit_bcd !== exp_bcd(exp_cr)) begin
          bad++; $display("FAIL rand_coin it%0d k%0d: credit=%0d locked=%b bcd=%h want %0d/%b",
                          it, k, credit, locked_led, credit_bcd, exp_cr, lk);
        end
      end
      total++;
      if (rej_cnt - r0 !== exp_rej) begin
        bad++; $display("FAIL rand_rejects it%0d: got %0d want %0d", it, rej_cnt - r0, exp_rej);
      end
      p0 = pulse_cnt;
      if (lk) begin
        if ($urandom_range(0, 1) == 1) begin
          press(1'b0);
          total++;
          if (credit !== 8'(exp_cr) || locked_led !== 1'b1) begin
            bad++; $display("FAIL rand_cancel_locked it%0d: credit=%0d locked=%b want %0d/1",
                            it, credit, locked_led, exp_cr);
          end
        end
        press(1'b1);
        exp_pay = exp_cr - 25;
      end else begin
        press(1'b0);
        exp_pay = exp_cr;
      end
      wait_idle(400);
      total++;
      if (pulse_cnt - p0 !== exp_pay / 5) begin
        bad++; $display("FAIL rand_pulses it%0d: got %0d want %0d", it, pulse_cnt - p0, exp_pay / 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_change_locked();
    test_simul();
    test_cancel_timeout();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
